// File: rtl/shift_register.sv
// Loadable mantissa shifter: right mode aligns by a fixed count, left mode
// normalizes until the MSB is set or the shift budget runs out. One bit per clock.
module shift_register #(
  parameter int Mantissa_Size = 23,
  parameter int Exponent_Size = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     load,
  input  logic                     direction,
  input  logic [Mantissa_Size:0]   unshifted,
  input  logic [Exponent_Size-1:0] no_of_shifts,
  output logic [Mantissa_Size:0]   shifted,
  output logic                     done
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    FIN  = 2'b10
  } state_t;

  state_t                   state, state_n;
  logic [Mantissa_Size:0]   shifted_n;
  logic [Exponent_Size-1:0] count, count_n;
  logic                     dir, dir_n;
  logic                     done_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      shifted <= '0;
      count   <= '0;
      dir     <= 1'b0;
      done    <= 1'b0;
    end else if (enable) begin
      state   <= state_n;
      shifted <= shifted_n;
      count   <= count_n;
      dir     <= dir_n;
      done    <= done_n;
    end
  end

  always_comb begin
    state_n   = state;
    shifted_n = shifted;
    count_n   = count;
    dir_n     = dir;
    done_n    = done;
    if (load) begin
      shifted_n = unshifted;
      count_n   = no_of_shifts;
      dir_n     = direction;
      done_n    = 1'b0;
      state_n   = BUSY;
    end else begin
      case (state)
        BUSY: begin
          // Left mode stops as soon as the hidden-1 position is occupied.
          if ((count == '0) || (!dir && shifted[Mantissa_Size])) begin
            state_n = FIN;
            done_n  = 1'b1;
          end else begin
            shifted_n = dir ? (shifted >> 1) : (shifted << 1);
            count_n   = count - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_register.sv
// Directed self-checking bench for shift_register (default 24-bit data path).
module tb_shift_register;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b1;
  logic        load = 1'b0;
  logic        direction = 1'b0;
  logic [23:0] unshifted = '0;
  logic [7:0]  no_of_shifts = '0;
  logic [23:0] shifted;
  logic        done;

  int errors = 0;
  int checks = 0;

  shift_register #(.Mantissa_Size(23), .Exponent_Size(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .load(load),
    .direction(direction), .unshifted(unshifted),
    .no_of_shifts(no_of_shifts), .shifted(shifted), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [23:0] es, input logic ed);
    chk({tag, ".shifted"}, shifted, es);
    chk({tag, ".done"}, {23'd0, done}, {23'd0, ed});
  endtask

  // Leaves the bench 1ns after load edge 0 with load deasserted.
  task automatic do_load(input logic [23:0] data, input logic [7:0] n, input logic dir);
    unshifted    = data;
    no_of_shifts = n;
    direction    = dir;
    load         = 1'b1;
    tick(1);
    load         = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    tick(2);
    chk_out("reset", 24'h000000, 1'b0);
    reset = 1'b0;
    tick(1);
    chk_out("idle", 24'h000000, 1'b0);

    // Right align by 5
    do_load(24'h6E2AE6, 8'd5, 1'b1);
    chk_out("right.e0", 24'h6E2AE6, 1'b0);
    tick(5);
    chk_out("right.e5", 24'h037157, 1'b0);
    tick(1);
    chk_out("right.e6", 24'h037157, 1'b1);
    // Inputs changing without load have no effect in DONE
    unshifted = 24'hFFFFFF; no_of_shifts = 8'd9; direction = 1'b0;
    tick(3);
    chk_out("right.hold", 24'h037157, 1'b1);

    // Left normalize, stops after 5 shifts
    do_load(24'h062AE6, 8'd6, 1'b0);
    tick(5);
    chk_out("left.e5", 24'hC55CC0, 1'b0);
    tick(1);
    chk_out("left.e6", 24'hC55CC0, 1'b1);

    // Left, budget-limited
    do_load(24'h000001, 8'd3, 1'b0);
    tick(3);
    chk_out("budget.e3", 24'h000008, 1'b0);
    tick(1);
    chk_out("budget.e4", 24'h000008, 1'b1);

    // Zero count
    do_load(24'hABCDEF, 8'd0, 1'b1);
    chk_out("zero.e0", 24'hABCDEF, 1'b0);
    tick(1);
    chk_out("zero.e1", 24'hABCDEF, 1'b1);

    // Left with MSB already set
    do_load(24'h800001, 8'd4, 1'b0);
    tick(1);
    chk_out("msb.e1", 24'h800001, 1'b1);

    // All-zero left uses the full budget
    do_load(24'h000000, 8'd3, 1'b0);
    tick(3);
    chk_out("allzero.e3", 24'h000000, 1'b0);
    tick(1);
    chk_out("allzero.e4", 24'h000000, 1'b1);

    // Right with count beyond the width
    do_load(24'hFFFFFF, 8'd30, 1'b1);
    tick(23);
    chk_out("wide.e23", 24'h000001, 1'b0);
    tick(7);
    chk_out("wide.e30", 24'h000000, 1'b0);
    tick(1);
    chk_out("wide.e31", 24'h000000, 1'b1);

    // Enable low for 3 cycles mid-BUSY, including an attempted load
    do_load(24'h6E2AE6, 8'd5, 1'b1);
    tick(2);
    chk_out("en.e2", 24'h1B8AB9, 1'b0);
    enable = 1'b0;
    unshifted = 24'h123456; no_of_shifts = 8'd1; load = 1'b1;
    tick(3);
    chk_out("en.frozen", 24'h1B8AB9, 1'b0);
    load = 1'b0;
    enable = 1'b1;
    tick(3);
    chk_out("en.e5", 24'h037157, 1'b0);
    tick(1);
    chk_out("en.e6", 24'h037157, 1'b1);

    // Reset mid-BUSY
    do_load(24'h6E2AE6, 8'd5, 1'b1);
    tick(2);
    reset = 1'b1;
    tick(1);
    chk_out("rst.busy", 24'h000000, 1'b0);
    reset = 1'b0;
    tick(3);
    chk_out("rst.idle", 24'h000000, 1'b0);

    // Reload on edge 2 of a 5-shift right operation
    do_load(24'h6E2AE6, 8'd5, 1'b1);
    tick(1);
    do_load(24'hF00000, 8'd4, 1'b1);
    chk_out("reload.e2", 24'hF00000, 1'b0);
    tick(4);
    chk_out("reload.s4", 24'h0F0000, 1'b0);
    tick(1);
    chk_out("reload.done", 24'h0F0000, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_register.md
Name: shift_register

Overview:
- Loadable, multi-cycle mantissa shifter for the floating-point ALU datapath. Width is Mantissa_Size+1, which includes the hidden 1 of 1.m.
- Right mode aligns a mantissa by a given exponent difference, one bit per clock.
- Left mode normalizes: it shifts left until the MSB is 1 or the shift budget is used up.
- Signals completion with done.

Parameters:
- Mantissa_Size, 23: stored mantissa bits; data path is Mantissa_Size+1 bits wide.
- Exponent_Size, 8: width of the shift-count input.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- enable  input  1  clock enable; when low, all state holds
- load  input  1  capture unshifted/no_of_shifts/direction and start an operation
- direction  input  1  1 = shift right (align), 0 = shift left (normalize)
- unshifted  input  Mantissa_Size+1  data to shift
- no_of_shifts  input  Exponent_Size  maximum number of 1-bit shifts
- shifted  output  Mantissa_Size+1  working register contents (registered)
- done  output  1  operation complete (registered)

Behaviour:
- All state changes occur on the rising edge of clk. Priority order: reset > !enable > load > shift.
- Reset:
  - shifted=0, internal count=0, stored direction=0.
  - done=0; state=IDLE.
- enable=0: shifted, count, state and done all hold, including during load.
- States:
  - IDLE: after reset; done=0, no shifting.
  - BUSY: shifting.
  - DONE: done=1, shifted holds.
- Load (enable=1, load=1), from any state:
  - shifted<=unshifted; count<=no_of_shifts; direction latched internally.
  - done<=0; state<=BUSY.
  - A load during BUSY aborts and restarts.
- BUSY, each enabled cycle with load=0:
  - Terminate when count==0, or when the latched direction is left and shifted[Mantissa_Size]==1. On termination: no shift, state<=DONE, done<=1.
  - Otherwise:
    - Right: shifted<=shifted>>1, zero fill at MSB.
    - Left: shifted<=shifted<<1, zero fill at LSB.
    - count<=count-1.
- Latency for N performed shifts:
  - With the load edge as edge 0, shifts occur on edges 1..N.
  - done rises on edge N+1.
  - shifted holds its final value from edge N onward.
- Left mode performs min(no_of_shifts, leading-zero count) shifts.
- All-zero data in left mode shifts no_of_shifts times, leaving zero.
- no_of_shifts=0: zero shifts; done on edge 1.
- Left mode with MSB already 1 at load: zero shifts; done on edge 1.
- Right mode with no_of_shifts ≥ Mantissa_Size+1: result is 0 after Mantissa_Size+1 shifts. Shifting continues until count reaches 0.
- DONE holds shifted and done=1 until the next load or reset.
- Changing direction, unshifted or no_of_shifts while not loading has no effect.

Test Plan:
- Right align:
  - Stimulus: unshifted=0110_1110_0010_1010_1110_0110, no_of_shifts=5, direction=1, load for one cycle.
  - Required: shifted=0000_0011_0111_0001_0101_0111 after the 5th post-load edge; done=1 one edge later.
- Left normalize with early stop:
  - Stimulus: unshifted=0000_0110_0010_1010_1110_0110, no_of_shifts=6, direction=0.
  - Required: stops after 5 shifts with shifted=1100_0101_0101_1100_1100_0000; done rises on edge 6.
- Left, budget-limited:
  - Stimulus: unshifted=0x000001, no_of_shifts=3, direction=0.
  - Required: shifted=0x000008; done on edge 4.
- Zero count:
  - Stimulus: no_of_shifts=0, any data.
  - Required: shifted=unshifted; done=1 on edge 1.
- Enable and reset:
  - Stimulus: deassert enable mid-BUSY for 3 cycles.
  - Required: shifted and count frozen, result identical but delayed 3 cycles.
  - Stimulus: assert reset mid-BUSY.
  - Required: shifted=0, done=0 on the next edge.
- Reload while busy:
  - Stimulus: second load on edge 2 of a 5-shift right operation.
  - Required: restarts; result reflects only the second operand and count.
